ecc_decoder: RTL and testbench
==============================

Name: ecc_decoder

Overview:
- Read-side checker/corrector paired with the page ECC encoder.
- Takes one 128-bit page word (8 halfwords) plus its stored 8-bit (136,128) check code.
- Recomputes the parity, forms the syndrome, and corrects a single flipped data bit. Flags codes it cannot map to a data bit.
- Sits between the packet SRAM read port and the dequeue datapath. Two-stage pipeline with valid/ready handshakes on both sides, plus saturating error statistics.

Parameters:
CNT_W, 16, width of each saturating error counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  page word and code are valid
in_ready  output  1  decoder can accept a word this cycle
in_data_0..in_data_7  input  16 each  halfwords 0..7 of the page word
in_code  input  8  stored check code read alongside the data
out_valid  output  1  corrected word is available
out_ready  input  1  downstream accepts the word
out_data_0..out_data_7  output  16 each  corrected halfwords
out_corr  output  1  this word had a single data-bit error, now corrected
out_uncorr  output  1  syndrome not mappable; data passed through unmodified
out_syndrome  output  8  syndrome of this word (for debug logging)
cnt_clr  input  1  synchronous clear of both counters
corr_cnt  output  CNT_W  number of corrected words, saturating
uncorr_cnt  output  CNT_W  number of uncorrectable words, saturating

Behaviour:
- Bit numbering: data bit i = 16*h + j (halfword h, bit j). Its code position is P = i+1, in the range 1..128.
- Parity: check bit k = XOR of all data bits whose P has bit k set, for k = 0..7. Bit 7 therefore equals data bit 127 alone. This is identical to the encoder's function.
- Syndrome: S = recomputed code XOR in_code.
  - S = 0: clean word.
  - 1 <= S <= 128: flip data bit S-1; out_corr = 1.
  - S > 128: out_uncorr = 1; data is not modified.
- Known limitation: a check-bit-only error gives S a power of two. The decoder attributes it to data bit S-1 and miscorrects. This is accepted; the verifier must not flag it.
- Stage 1 (s1): on an input handshake (in_valid && in_ready), register the data and S.
- Stage 2 (s2): register the corrected data, the flags and S.
- Stall and flow control:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1, combinational and with no dependence on in_valid.
- Latency: 2 cycles from an input handshake to out_valid, with no stalls. Throughput is 1 word per cycle.
- Under back-pressure, s2 holds its data, flags and S stable while out_valid = 1 and out_ready = 0. No word is dropped or duplicated.
- Counters:
  - On an output handshake, corr_cnt increments if out_corr = 1 and uncorr_cnt increments if out_uncorr = 1.
  - Each counter saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; a handshake in that cycle is not counted.
- Reset (asynchronous, at any time, including mid-stream):
  - s1_valid, s2_valid, out_valid = 0.
  - All out_data, out_corr, out_uncorr, out_syndrome = 0.
  - Both counters = 0.
  - in_ready = 1 in the first cycle after reset deassertion.
  - Words in flight are discarded.

Decomposition:
- Shared package ecc_pkg holds:
  - PAGE_HW = 8, HW_W = 16, CODE_W = 8, MAX_POS = 128
  - the check-bit function as a function over the packed 128-bit word, so the encoder and decoder share one definition.
- Sub-module ecc_syndrome (combinational) computes the 8-bit syndrome from the data and the stored code, and is instantiated in stage 1. Correction and counters stay in ecc_decoder.

Test Plan:
- Clean word: data 0, code 8'h00, out_ready = 1 -> out_valid on the 2nd cycle after the handshake; data 0, S = 0, no flags, counters unchanged.
- Single data error: encode data_2 = 16'h0000, inject data_2[5] = 1 (i = 37), keep the original code -> S = 8'h26, out_data_2 = 0, out_corr = 1, corr_cnt = 1.
- MSB bit: data_7 = 16'h8000 with code 8'h00 -> S = 8'h80, data_7 corrected to 0, out_corr = 1.
- Uncorrectable: data 0 with code 8'hFF -> S = 8'hFF, out_uncorr = 1, data unchanged, uncorr_cnt = 1.
- Back-pressure: stream 4 words with out_ready low for 3 cycles -> in_ready drops after 2 words are accepted, output holds stable, then all 4 words emerge in order exactly once. Also: assert rst mid-stream -> outputs and counters go to 0 immediately.
- Saturation and clear: CNT_W = 2, send 5 corrected words -> corr_cnt stays at 3. Assert cnt_clr in the same cycle as a corrected handshake -> counter = 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared page ECC constants and the (136,128) check-bit function
package ecc_pkg;
   localparam int PAGE_HW = 8;
   localparam int HW_W    = 16;
   localparam int CODE_W  = 8;
   localparam int MAX_POS = 128;
   localparam int DATA_W  = PAGE_HW * HW_W;

   // check bit k covers every data bit whose position (index+1) has bit k set
   function automatic logic [CODE_W-1:0] ecc_parity(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] c;
      c = '0;
      for (int k = 0; k < CODE_W; k++)
         for (int i = 0; i < DATA_W; i++)
            if (((i + 1) & (1 << k)) != 0) c[k] = c[k] ^ d[i];
      return c;
   endfunction
endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: recomputed parity XOR stored code
module ecc_syndrome
   import ecc_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [CODE_W-1:0] code_i,
   output logic [CODE_W-1:0] syndrome_o
);
   assign syndrome_o = ecc_parity(data_i) ^ code_i;
endmodule

// File: rtl/ecc_decoder.sv
// ecc_decoder: two-stage page word checker/corrector with valid/ready flow
// control and saturating corrected/uncorrectable word counters
module ecc_decoder
   import ecc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HW_W-1:0]   in_data_0,
   input  logic [HW_W-1:0]   in_data_1,
   input  logic [HW_W-1:0]   in_data_2,
   input  logic [HW_W-1:0]   in_data_3,
   input  logic [HW_W-1:0]   in_data_4,
   input  logic [HW_W-1:0]   in_data_5,
   input  logic [HW_W-1:0]   in_data_6,
   input  logic [HW_W-1:0]   in_data_7,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HW_W-1:0]   out_data_0,
   output logic [HW_W-1:0]   out_data_1,
   output logic [HW_W-1:0]   out_data_2,
   output logic [HW_W-1:0]   out_data_3,
   output logic [HW_W-1:0]   out_data_4,
   output logic [HW_W-1:0]   out_data_5,
   output logic [HW_W-1:0]   out_data_6,
   output logic [HW_W-1:0]   out_data_7,
   output logic              out_corr,
   output logic              out_uncorr,
   output logic [CODE_W-1:0] out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);
   logic [DATA_W-1:0] in_word, flip;
   logic [CODE_W-1:0] syn;
   logic adv1, adv2, in_hs, out_hs, fix;
   logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
   logic [CODE_W-1:0] s1_syn_q, s1_syn_d, s2_syn_q, s2_syn_d;
   logic s2_corr_q, s2_corr_d, s2_unc_q, s2_unc_d;
   logic [CNT_W-1:0] corr_q, corr_d, unc_q, unc_d;

   assign in_word = {in_data_7, in_data_6, in_data_5, in_data_4,
                     in_data_3, in_data_2, in_data_1, in_data_0};

   ecc_syndrome u_syn (.data_i(in_word), .code_i(in_code), .syndrome_o(syn));

   assign adv2     = !s2_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;
   assign in_hs    = in_valid && adv1;
   assign out_hs   = s2_valid_q && out_ready;
   // syndromes 1..128 name a data bit; anything above has no data position
   assign fix      = (s1_syn_q != '0) && (s1_syn_q <= CODE_W'(MAX_POS));
   assign flip     = fix ? (DATA_W'(1) << (s1_syn_q - CODE_W'(1))) : '0;

   always_comb begin
      s1_valid_d = adv1 ? in_valid : s1_valid_q;
      s1_data_d  = in_hs ? in_word : s1_data_q;
      s1_syn_d   = in_hs ? syn : s1_syn_q;
      s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
      s2_data_d  = adv2 ? s1_data_q ^ flip : s2_data_q;
      s2_corr_d  = adv2 ? fix : s2_corr_q;
      s2_unc_d   = adv2 ? (s1_syn_q > CODE_W'(MAX_POS)) : s2_unc_q;
      s2_syn_d   = adv2 ? s1_syn_q : s2_syn_q;
      corr_d     = cnt_clr ? '0 : (out_hs && s2_corr_q && corr_q != '1) ? corr_q + CNT_W'(1) : corr_q;
      unc_d      = cnt_clr ? '0 : (out_hs && s2_unc_q && unc_q != '1) ? unc_q + CNT_W'(1) : unc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_syn_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_corr_q  <= 1'b0;
         s2_unc_q   <= 1'b0;
         s2_syn_q   <= '0;
         corr_q     <= '0;
         unc_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_syn_q   <= s1_syn_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_corr_q  <= s2_corr_d;
         s2_unc_q   <= s2_unc_d;
         s2_syn_q   <= s2_syn_d;
         corr_q     <= corr_d;
         unc_q      <= unc_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_corr     = s2_corr_q;
   assign out_uncorr   = s2_unc_q;
   assign out_syndrome = s2_syn_q;
   assign corr_cnt     = corr_q;
   assign uncorr_cnt   = unc_q;
   assign {out_data_7, out_data_6, out_data_5, out_data_4,
           out_data_3, out_data_2, out_data_1, out_data_0} = s2_data_q;
endmodule

// File: tb/tb_ecc_decoder.sv
// tb_ecc_decoder: randomized scoreboard bench plus directed cases for ecc_decoder
module tb_ecc_decoder;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic [127:0] data;
      logic [7:0]   syn;
      logic         corr;
      logic         unc;
   } exp_t;

   logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_corr, out_uncorr, cnt_clr;
   logic [15:0] in_data_0, in_data_1, in_data_2, in_data_3, in_data_4, in_data_5, in_data_6, in_data_7;
   logic [15:0] out_data_0, out_data_1, out_data_2, out_data_3, out_data_4, out_data_5, out_data_6, out_data_7;
   logic [7:0] in_code, out_syndrome;
   logic [CW-1:0] corr_cnt, uncorr_cnt;
   logic [127:0] out_word;

   int checks = 0, errors = 0;
   int m_corr = 0, m_unc = 0;
   exp_t q[$];
   logic prev_hold = 0;
   logic [127:0] prev_word;
   logic [7:0] prev_syn;

   ecc_decoder #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
      .in_data_4(in_data_4), .in_data_5(in_data_5), .in_data_6(in_data_6), .in_data_7(in_data_7),
      .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
      .out_data_0(out_data_0), .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
      .out_data_4(out_data_4), .out_data_5(out_data_5), .out_data_6(out_data_6), .out_data_7(out_data_7),
      .out_corr(out_corr), .out_uncorr(out_uncorr), .out_syndrome(out_syndrome),
      .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   assign out_word = {out_data_7, out_data_6, out_data_5, out_data_4,
                      out_data_3, out_data_2, out_data_1, out_data_0};

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // XOR of the positions of all set bits equals the check code
   function automatic logic [7:0] ref_code(input logic [127:0] d);
      logic [7:0] p = 0;
      for (int i = 0; i < 128; i++) if (d[i]) p ^= 8'(i + 1);
      return p;
   endfunction

   function automatic exp_t ref_model(input logic [127:0] d, input logic [7:0] c);
      exp_t e;
      e.syn  = ref_code(d) ^ c;
      e.corr = (e.syn >= 1) && (e.syn <= 128);
      e.unc  = e.syn > 128;
      for (int i = 0; i < 128; i++) e.data[i] = d[i] ^ (e.corr && int'(e.syn) == i + 1);
      return e;
   endfunction

   task automatic step(input logic v, input logic [127:0] d, input logic [7:0] c,
                       input logic ordy, input logic clr);
      exp_t e;
      logic ohs;
      @(negedge clk);
      chk("corr_cnt", corr_cnt, m_corr);
      chk("uncorr_cnt", uncorr_cnt, m_unc);
      if (prev_hold) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_word, prev_word);
         chk("hold_syn", out_syndrome, prev_syn);
      end
      in_valid = v;
      {in_data_7, in_data_6, in_data_5, in_data_4, in_data_3, in_data_2, in_data_1, in_data_0} = d;
      in_code = c;
      out_ready = ordy;
      cnt_clr = clr;
      #1;
      chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
      if (q.size() == 0) chk("idle_valid", out_valid, 0);
      ohs = out_valid && out_ready;
      e.corr = 0;
      e.unc = 0;
      if (ohs) begin
         if (q.size() == 0) chk("spurious_out", 1, 0);
         else begin
            e = q.pop_front();
            chk("out_data", out_word, e.data);
            chk("out_syn", out_syndrome, e.syn);
            chk("out_corr", out_corr, e.corr);
            chk("out_unc", out_uncorr, e.unc);
         end
      end
      if (clr) begin
         m_corr = 0;
         m_unc = 0;
      end else if (ohs) begin
         if (e.corr && m_corr < CMAX) m_corr++;
         if (e.unc && m_unc < CMAX) m_unc++;
      end
      prev_hold = out_valid && !out_ready;
      prev_word = out_word;
      prev_syn = out_syndrome;
      if (v && in_ready) q.push_back(ref_model(d, c));
   endtask

   task automatic directed(input logic [127:0] d, input logic [7:0] c, input logic [7:0] es,
                           input logic ec, input logic eu, input logic [127:0] ed);
      step(1, d, c, 1, 0);
      step(0, '0, '0, 1, 0);
      chk("lat1_valid", out_valid, 0);
      step(0, '0, '0, 1, 0);
      chk("lat2_valid", out_valid, 1);
      chk("dir_syn", out_syndrome, es);
      chk("dir_corr", out_corr, ec);
      chk("dir_unc", out_uncorr, eu);
      chk("dir_data", out_word, ed);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] d, w;
      logic [7:0] c;
      int k;
      rst = 1;
      in_valid = 0; out_ready = 0; cnt_clr = 0; in_code = 0;
      {in_data_7, in_data_6, in_data_5, in_data_4, in_data_3, in_data_2, in_data_1, in_data_0} = '0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_word, 0);
      chk("rst_syn", out_syndrome, 0);
      chk("rst_corr_cnt", corr_cnt, 0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("rst_in_ready", in_ready, 1);

      directed('0, 8'h00, 8'h00, 0, 0, '0);
      w = '0; w[37] = 1'b1;
      directed(w, 8'h00, 8'h26, 1, 0, '0);
      w = '0; w[127] = 1'b1;
      directed(w, 8'h00, 8'h80, 1, 0, '0);
      directed('0, 8'hFF, 8'hFF, 0, 1, '0);
      step(0, '0, '0, 1, 0);
      chk("dir_corr_cnt", corr_cnt, 2);
      chk("dir_unc_cnt", uncorr_cnt, 1);

      // four words against a stalled output, then release
      for (int i = 0; i < 4; i++) begin
         d = rnd128();
         step(1, d, ref_code(d), i >= 3, 0);
         if (i == 2) chk("bp_in_ready", in_ready, 0);
      end
      for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 0);
      chk("bp_drained", q.size(), 0);

      for (int i = 0; i < 5; i++) begin
         w = '0; w[i * 7] = 1'b1;
         step(1, w, 8'h00, 1, 0);
      end
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
      chk("sat_corr_cnt", corr_cnt, CMAX);
      w = '0; w[5] = 1'b1;
      step(1, w, 8'h00, 1, 0);
      step(0, '0, '0, 1, 0);
      step(0, '0, '0, 1, 1);
      step(0, '0, '0, 1, 0);
      chk("clr_corr_cnt", corr_cnt, 0);

      for (int n = 0; n < 500; n++) begin
         d = rnd128();
         c = ref_code(d);
         k = $urandom_range(0, 3);
         if (k == 1) d[$urandom_range(0, 127)] ^= 1'b1;
         else if (k == 2) c = 8'($urandom);
         else if (k == 3) c[$urandom_range(0, 7)] ^= 1'b1;
         step($urandom_range(0, 3) != 0, d, c, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      end

      // asynchronous reset with the pipeline full
      for (int i = 0; i < 2; i++) begin
         w = '0; w[i + 3] = 1'b1;
         step(1, w, 8'h00, 0, 0);
      end
      step(0, '0, '0, 0, 0);
      @(negedge clk);
      in_valid = 0;
      #2 rst = 1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_word, 0);
      chk("mid_rst_syn", out_syndrome, 0);
      chk("mid_rst_flags", {out_corr, out_uncorr}, 0);
      chk("mid_rst_corr_cnt", corr_cnt, 0);
      chk("mid_rst_unc_cnt", uncorr_cnt, 0);
      q.delete();
      m_corr = 0; m_unc = 0; prev_hold = 0;
      @(negedge clk);
      rst = 0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      for (int n = 0; n < 60; n++) begin
         d = rnd128();
         c = ref_code(d);
         if ($urandom_range(0, 1) != 0) d[$urandom_range(0, 127)] ^= 1'b1;
         step(1, d, c, $urandom_range(0, 1) != 0, 0);
      end
      for (int n = 0; n < 20 && q.size() != 0; n++) step(0, '0, '0, 1, 0);
      chk("final_drain", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
